// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch program counter with boot, stall hold and deferred redirect
// Optional feature macro: BRANCH_DELAY_SLOT_EN (defined: slot instruction executes, fetch_kill tied low)
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] pc_x,
  input  logic [25:0] imm_x,
  input  logic [31:0] reg_target,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  output logic [31:0] pc_f_plus4,
  output logic        valid_f,
  output logic        fetch_kill,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD       = 2'd2,
    HOLD_REDIR = 2'd3
  } state_t;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_REG    = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        pend_mis, pend_mis_nxt;
  logic        mis_nxt;
  logic        accept;
  logic        redir_req;
  logic [31:0] target;
  logic        target_mis;
  logic [31:0] pc_x_plus4;

  assign pc_x_plus4 = pc_x + 32'd4;
  // Reserved kind 2'b11 never produces a redirect, so it falls through to PC+4.
  assign redir_req  = take_branch && (redirect_kind != 2'b11);

  // Target selection from the X-stage redirect source.
  always_comb begin
    target     = pc_x_plus4;
    target_mis = 1'b0;
    case (redirect_kind)
      KIND_BRANCH: target = pc_x_plus4 + {{14{imm_x[15]}}, imm_x[15:0], 2'b00};
      KIND_JUMP:   target = {pc_x_plus4[31:28], imm_x, 2'b00};
      KIND_REG: begin
        target     = {reg_target[31:2], 2'b00};
        target_mis = |reg_target[1:0];
      end
      default:     target = pc_x_plus4;
    endcase
  end

  // Next-state, next-PC and pending-redirect decisions; a redirect counts as
  // accepted on the edge where its target is loaded into the PC.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_pc_nxt  = pend_pc;
    pend_mis_nxt = pend_mis;
    mis_nxt      = misaligned;
    accept       = 1'b0;
    imem_re      = 1'b0;
    case (state)
      BOOT: begin
        imem_re   = 1'b1;
        pc_nxt    = pc + 32'd4;
        state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          imem_re = 1'b1;
          if (redir_req) begin
            pc_nxt = target;
            accept = 1'b1;
            if (redirect_kind == KIND_REG) mis_nxt = target_mis;
          end else begin
            pc_nxt = pc + 32'd4;
          end
        end else if (redir_req) begin
          pend_pc_nxt  = target;
          pend_mis_nxt = (redirect_kind == KIND_REG) ? target_mis : misaligned;
          state_nxt    = HOLD_REDIR;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = RUN;
        end
      end
      HOLD_REDIR: begin
        if (!stall) begin
          pc_nxt    = pend_pc;
          mis_nxt   = pend_mis;
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC, pending target and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pend_mis   <= 1'b0;
      misaligned <= 1'b0;
      fetch_kill <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_pc    <= pend_pc_nxt;
      pend_mis   <= pend_mis_nxt;
      misaligned <= mis_nxt;
`ifdef BRANCH_DELAY_SLOT_EN
      fetch_kill <= 1'b0;
`else
      fetch_kill <= accept;
`endif
    end
  end

  assign imem_addr  = pc;
  assign pc_f_plus4 = pc + 32'd4;
  assign valid_f    = (state != BOOT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        take_branch;
  logic [1:0]  redirect_kind;
  logic [31:0] pc_x;
  logic [25:0] imm_x;
  logic [31:0] reg_target;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] pc_f_plus4;
  logic        valid_f;
  logic        fetch_kill;
  logic        misaligned;

  int checks = 0;
  int passed = 0;
  logic kill_exp;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h4000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .take_branch(take_branch),
    .redirect_kind(redirect_kind), .pc_x(pc_x), .imm_x(imm_x),
    .reg_target(reg_target), .imem_addr(imem_addr), .imem_re(imem_re),
    .pc_f_plus4(pc_f_plus4), .valid_f(valid_f), .fetch_kill(fetch_kill),
    .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef BRANCH_DELAY_SLOT_EN
    kill_exp = 1'b0;
`else
    kill_exp = 1'b1;
`endif
    rst_n = 1'b0; stall = 1'b0; take_branch = 1'b0; redirect_kind = 2'b00;
    pc_x = '0; imm_x = '0; reg_target = '0;
    step(); step();
    chk("rst_addr", imem_addr, 32'h4000_0000);
    chk("rst_valid", {31'd0, valid_f}, 32'd0);
    chk("rst_re", {31'd0, imem_re}, 32'd1);
    chk("rst_kill", {31'd0, fetch_kill}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_plus4", pc_f_plus4, 32'h4000_0004);

    rst_n = 1'b1;
    step();
    chk("free1_addr", imem_addr, 32'h4000_0004);
    chk("free1_valid", {31'd0, valid_f}, 32'd1);
    step();
    chk("free2_addr", imem_addr, 32'h4000_0008);
    chk("free2_valid", {31'd0, valid_f}, 32'd1);

    pc_x = 32'h4000_0010; redirect_kind = 2'b00; imm_x = 26'h000_FFFC; take_branch = 1'b1;
    step();
    chk("br_addr", imem_addr, 32'h4000_0004);
    chk("br_kill", {31'd0, fetch_kill}, {31'd0, kill_exp});
    take_branch = 1'b0;
    step();
    chk("br_next", imem_addr, 32'h4000_0008);
    chk("br_kill_drop", {31'd0, fetch_kill}, 32'd0);

    redirect_kind = 2'b10; reg_target = 32'h1234_5677; take_branch = 1'b1;
    step();
    chk("reg_addr", imem_addr, 32'h1234_5674);
    chk("reg_mis", {31'd0, misaligned}, 32'd1);
    take_branch = 1'b0;
    step();
    chk("reg_next", imem_addr, 32'h1234_5678);
    chk("reg_mis_hold", {31'd0, misaligned}, 32'd1);

    reg_target = 32'h0000_1000; take_branch = 1'b1;
    step();
    chk("reg_al_addr", imem_addr, 32'h0000_1000);
    chk("reg_al_mis", {31'd0, misaligned}, 32'd0);

    redirect_kind = 2'b11;
    step();
    chk("rsvd_addr", imem_addr, 32'h0000_1004);
    chk("rsvd_kill", {31'd0, fetch_kill}, 32'd0);

    redirect_kind = 2'b10; reg_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    take_branch = 1'b0;
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    pc_x = 32'h4000_0020; redirect_kind = 2'b01; imm_x = 26'h10; take_branch = 1'b1;
    step();
    chk("jmp_addr", imem_addr, 32'h4000_0040);
    chk("jmp_kill", {31'd0, fetch_kill}, {31'd0, kill_exp});
    take_branch = 1'b0;
    step();
    chk("jmp_next", imem_addr, 32'h4000_0044);
    chk("jmp_kill_drop", {31'd0, fetch_kill}, 32'd0);

    stall = 1'b1; take_branch = 1'b1; redirect_kind = 2'b00;
    pc_x = 32'h4000_0100; imm_x = 26'h000_0008;
    step();
    chk("st1_addr", imem_addr, 32'h4000_0044);
    chk("st1_re", {31'd0, imem_re}, 32'd0);
    chk("st1_valid", {31'd0, valid_f}, 32'd1);
    pc_x = 32'h5000_0000; imm_x = 26'h0;
    step();
    chk("st2_addr", imem_addr, 32'h4000_0044);
    take_branch = 1'b0;
    step();
    chk("st3_addr", imem_addr, 32'h4000_0044);
    chk("st3_kill", {31'd0, fetch_kill}, 32'd0);
    stall = 1'b0;
    step();
    chk("st_tgt", imem_addr, 32'h4000_0124);
    chk("st_kill", {31'd0, fetch_kill}, {31'd0, kill_exp});
    step();
    chk("st_tgt4", imem_addr, 32'h4000_0128);
    chk("st_kill_drop", {31'd0, fetch_kill}, 32'd0);

    stall = 1'b1;
    step();
    chk("hold_addr", imem_addr, 32'h4000_0128);
    chk("hold_re", {31'd0, imem_re}, 32'd0);
    stall = 1'b0;
    step();
    chk("hold_rel", imem_addr, 32'h4000_012C);
    chk("hold_kill", {31'd0, fetch_kill}, 32'd0);

    redirect_kind = 2'b10; reg_target = 32'h0000_2001; take_branch = 1'b1;
    step();
    chk("mis2_addr", imem_addr, 32'h0000_2000);
    chk("mis2_flag", {31'd0, misaligned}, 32'd1);

    stall = 1'b1; redirect_kind = 2'b00; pc_x = 32'h4000_0100; imm_x = 26'h000_0008;
    step();
    chk("hr_addr", imem_addr, 32'h0000_2000);
    take_branch = 1'b0; rst_n = 1'b0;
    step();
    chk("hr_rst_addr", imem_addr, 32'h4000_0000);
    chk("hr_rst_valid", {31'd0, valid_f}, 32'd0);
    chk("hr_rst_mis", {31'd0, misaligned}, 32'd0);
    chk("hr_rst_kill", {31'd0, fetch_kill}, 32'd0);
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("hr_boot_next", imem_addr, 32'h4000_0004);
    chk("hr_boot_kill", {31'd0, fetch_kill}, 32'd0);
    step();
    chk("hr_boot_next2", imem_addr, 32'h4000_0008);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
